streaming_max_pool2d: RTL and testbench



---
 rtl/streaming_max_pool2d_pkg.sv | 19 +
 rtl/streaming_max_pool2d_if.sv | 26 ++
 rtl/streaming_max_pool2d_pool_window_counter.sv | 94 +++++++++
 rtl/streaming_max_pool2d.sv | 121 ++++++++++++
 tb/tb_streaming_max_pool2d.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/streaming_max_pool2d_pkg.sv
// Shared helpers for the pooling blocks: signed compare and dimension/index-width derivation.
package pooling_pkg;

  localparam int MAX_W = 32;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic wide_t signed_max(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic int out_dim(input int dim, input int k);
    return dim / k;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/streaming_max_pool2d_if.sv
// Input/output beat streams of the max pooler; slave is the pooler's view, master the neighbour's.
// data_out_0_last exists only when STREAMING_MAX_POOL_LAST_EN is defined.
interface streaming_max_pool2d_if #(
  parameter int PAR  = 2,
  parameter int PREC = 8
);
  logic [PAR-1:0][PREC-1:0] data_in_0;
  logic                     data_in_0_valid;
  logic                     data_in_0_ready;
  logic [PAR-1:0][PREC-1:0] data_out_0;
  logic                     data_out_0_valid;
  logic                     data_out_0_ready;
`ifdef STREAMING_MAX_POOL_LAST_EN
  logic                     data_out_0_last;

  modport slave  (input data_in_0, data_in_0_valid, data_out_0_ready,
                  output data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last);
  modport master (output data_in_0, data_in_0_valid, data_out_0_ready,
                  input data_in_0_ready, data_out_0, data_out_0_valid, data_out_0_last);
`else
  modport slave  (input data_in_0, data_in_0_valid, data_out_0_ready,
                  output data_in_0_ready, data_out_0, data_out_0_valid);
  modport master (output data_in_0, data_in_0_valid, data_out_0_ready,
                  input data_in_0_ready, data_out_0, data_out_0_valid);
`endif
endinterface

// File: rtl/streaming_max_pool2d_pool_window_counter.sv
// Nested group/column/row position counters for a K x K, stride-K pooling window,
// with first/last-of-window, in-region and final-pooled-beat flags.
module pool_window_counter
  import pooling_pkg::*;
#(
  parameter int GROUPS = 2,
  parameter int W      = 8,
  parameter int H      = 8,
  parameter int K      = 2,
  localparam int GW    = idx_w(GROUPS),
  localparam int OCW   = idx_w(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  output logic [GW-1:0]  grp,
  output logic [OCW-1:0] col_o,
  output logic           first,
  output logic           last,
  output logic           in_region,
  output logic           frame_last
);
  localparam int CW  = idx_w(W);
  localparam int RW  = idx_w(H);
  localparam int ORW = idx_w(H + 1);
  localparam int KW  = idx_w(K);
  localparam logic [GW-1:0]  G_MAX  = GW'(GROUPS - 1);
  localparam logic [CW-1:0]  W_MAX  = CW'(W - 1);
  localparam logic [RW-1:0]  H_MAX  = RW'(H - 1);
  localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);
  localparam logic [OCW-1:0] OUT_W  = OCW'(out_dim(W, K));
  localparam logic [ORW-1:0] OUT_H  = ORW'(out_dim(H, K));

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [KW-1:0]  col_k, row_k;
  logic [ORW-1:0] row_o;
  logic           grp_end, col_end, row_end;

  assign grp_end = (grp == G_MAX);
  assign col_end = (col == W_MAX);
  assign row_end = (row == H_MAX);

  // col_k/row_k and col_o/row_o track position modulo and divided by K without a divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp   <= '0;
      col   <= '0;
      col_k <= '0;
      col_o <= '0;
      row   <= '0;
      row_k <= '0;
      row_o <= '0;
    end else if (adv) begin
      if (!grp_end) begin
        grp <= grp + 1'b1;
      end else begin
        grp <= '0;
        if (!col_end) begin
          col <= col + 1'b1;
          if (col_k == K_MAX) begin
            col_k <= '0;
            col_o <= col_o + 1'b1;
          end else begin
            col_k <= col_k + 1'b1;
          end
        end else begin
          col   <= '0;
          col_k <= '0;
          col_o <= '0;
          if (row_end) begin
            row   <= '0;
            row_k <= '0;
            row_o <= '0;
          end else begin
            row <= row + 1'b1;
            if (row_k == K_MAX) begin
              row_k <= '0;
              row_o <= row_o + 1'b1;
            end else begin
              row_k <= row_k + 1'b1;
            end
          end
        end
      end
    end
  end

  assign in_region  = (col_o < OUT_W) && (row_o < OUT_H);
  assign first      = in_region && (col_k == '0) && (row_k == '0);
  assign last       = in_region && (col_k == K_MAX) && (row_k == K_MAX);
  assign frame_last = last && grp_end && (col_o == OUT_W - 1'b1) && (row_o == OUT_H - 1'b1);

endmodule

// File: rtl/streaming_max_pool2d.sv
// Streaming K x K / stride-K 2-D max pool over PAR-channel beats, registered valid/ready output.
// Define STREAMING_MAX_POOL_LAST_EN to add data_out_0_last on the final pooled beat of a frame.
module streaming_max_pool2d
  import pooling_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0         = 8,
  parameter int DATA_IN_0_PRECISION_1         = 3,
  parameter int DATA_IN_0_PARALLELISM_DIM_0   = 2,
  parameter int CHANNELS                      = 4,
  parameter int DATA_IN_0_WIDTH               = 8,
  parameter int DATA_IN_0_HEIGHT              = 8,
  parameter int KERNEL_SIZE                   = 2,
  parameter int DATA_OUT_0_PRECISION_0        = 8,
  parameter int DATA_OUT_0_PRECISION_1        = 3,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0  = 2
) (
  input logic                  clk,
  input logic                  rst,
  streaming_max_pool2d_if.slave bus
);
  localparam int PREC    = DATA_IN_0_PRECISION_0;
  localparam int PAR     = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int GROUPS  = CHANNELS / PAR;
  localparam int ENTRIES = out_dim(DATA_IN_0_WIDTH, KERNEL_SIZE) * GROUPS;
  localparam int IW      = idx_w(ENTRIES);
  localparam int GW      = idx_w(GROUPS);
  localparam int OCW     = idx_w(DATA_IN_0_WIDTH + 1);

  typedef logic [PAR-1:0][PREC-1:0] beat_t;

  if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 ||
      DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1 ||
      DATA_OUT_0_PARALLELISM_DIM_0 != DATA_IN_0_PARALLELISM_DIM_0) begin : g_bad_out_fmt
    $error("streaming_max_pool2d: output format must equal input format");
  end
  if (CHANNELS % PAR != 0) begin : g_bad_channels
    $error("streaming_max_pool2d: CHANNELS must be a multiple of the beat parallelism");
  end

  logic [GW-1:0]  grp;
  logic [OCW-1:0] col_o;
  logic           first, last, in_region, frame_last;
  logic           fire;
  logic [IW-1:0]  acc_idx;
  beat_t          din, acc_rd, merged, win_val, out_dat;
  beat_t          acc_q [ENTRIES];
  logic           out_vld;

  assign din                 = bus.data_in_0;
  assign bus.data_in_0_ready = !out_vld || bus.data_out_0_ready;
  assign fire                = bus.data_in_0_valid && bus.data_in_0_ready;

  pool_window_counter #(
    .GROUPS (GROUPS),
    .W      (DATA_IN_0_WIDTH),
    .H      (DATA_IN_0_HEIGHT),
    .K      (KERNEL_SIZE)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .adv        (fire),
    .grp        (grp),
    .col_o      (col_o),
    .first      (first),
    .last       (last),
    .in_region  (in_region),
    .frame_last (frame_last)
  );

  assign acc_idx = IW'(int'(col_o) * GROUPS + int'(grp));
  assign acc_rd  = acc_q[acc_idx];

  always_comb begin
    merged = '0;
    for (int l = 0; l < PAR; l++) begin
      merged[l] = PREC'(signed_max(MAX_W'($signed(acc_rd[l])), MAX_W'($signed(din[l]))));
    end
  end

  // First pixel loads rather than compares, so stale entries never leak (also makes K=1 correct)
  assign win_val = first ? din : merged;

  always_ff @(posedge clk) begin
    if (fire && in_region) begin
      acc_q[acc_idx] <= win_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (fire && last) begin
      out_vld <= 1'b1;
      out_dat <= win_val;
    end else if (out_vld && bus.data_out_0_ready) begin
      out_vld <= 1'b0;
    end
  end

  assign bus.data_out_0       = out_dat;
  assign bus.data_out_0_valid = out_vld;

`ifdef STREAMING_MAX_POOL_LAST_EN
  logic out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_last <= 1'b0;
    end else if (fire && last) begin
      out_last <= frame_last;
    end
  end

  assign bus.data_out_0_last = out_last;
`else
  logic unused_frame_last;
  assign unused_frame_last = frame_last;
`endif

endmodule

// File: tb/tb_streaming_max_pool2d.sv
// Scoreboard bench for streaming_max_pool2d: three instances (4x4 PAR=1, 4x4 CH=4 PAR=2, 5x5 PAR=1).
// Honours STREAMING_MAX_POOL_LAST_EN when defined.
module tb_streaming_max_pool2d;
  localparam int ND = 3;
  localparam int K  = 2;
  localparam int CFG_W   [ND] = '{4, 4, 5};
  localparam int CFG_H   [ND] = '{4, 4, 5};
  localparam int CFG_G   [ND] = '{1, 2, 1};
  localparam int CFG_PAR [ND] = '{1, 2, 1};

  typedef struct {
    logic [1:0][7:0] dat;
    int              cyc;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid  [ND];
  logic            in_ready  [ND];
  logic            out_valid [ND];
  logic            out_ready [ND];
  logic            out_last  [ND];
  logic [1:0][7:0] in_dat    [ND];
  logic [1:0][7:0] out_dat   [ND];

  int n_checks = 0;
  int n_fail   = 0;

  streaming_max_pool2d_if #(.PAR(1), .PREC(8)) if_a ();
  streaming_max_pool2d_if #(.PAR(2), .PREC(8)) if_b ();
  streaming_max_pool2d_if #(.PAR(1), .PREC(8)) if_c ();

  streaming_max_pool2d #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(1),
    .CHANNELS(1), .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4), .KERNEL_SIZE(2),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(3), .DATA_OUT_0_PARALLELISM_DIM_0(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

  streaming_max_pool2d #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(2),
    .CHANNELS(4), .DATA_IN_0_WIDTH(4), .DATA_IN_0_HEIGHT(4), .KERNEL_SIZE(2),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(3), .DATA_OUT_0_PARALLELISM_DIM_0(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  streaming_max_pool2d #(
    .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(1),
    .CHANNELS(1), .DATA_IN_0_WIDTH(5), .DATA_IN_0_HEIGHT(5), .KERNEL_SIZE(2),
    .DATA_OUT_0_PRECISION_0(8), .DATA_OUT_0_PRECISION_1(3), .DATA_OUT_0_PARALLELISM_DIM_0(1)
  ) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_a.data_in_0        = in_dat[0][0];
  assign if_b.data_in_0        = in_dat[1];
  assign if_c.data_in_0        = in_dat[2][0];
  assign if_a.data_in_0_valid  = in_valid[0];
  assign if_b.data_in_0_valid  = in_valid[1];
  assign if_c.data_in_0_valid  = in_valid[2];
  assign if_a.data_out_0_ready = out_ready[0];
  assign if_b.data_out_0_ready = out_ready[1];
  assign if_c.data_out_0_ready = out_ready[2];
  assign in_ready[0]  = if_a.data_in_0_ready;
  assign in_ready[1]  = if_b.data_in_0_ready;
  assign in_ready[2]  = if_c.data_in_0_ready;
  assign out_valid[0] = if_a.data_out_0_valid;
  assign out_valid[1] = if_b.data_out_0_valid;
  assign out_valid[2] = if_c.data_out_0_valid;
  assign out_dat[0]   = {8'h00, if_a.data_out_0[0]};
  assign out_dat[1]   = if_b.data_out_0;
  assign out_dat[2]   = {8'h00, if_c.data_out_0[0]};
`ifdef STREAMING_MAX_POOL_LAST_EN
  assign out_last[0] = if_a.data_out_0_last;
  assign out_last[1] = if_b.data_out_0_last;
  assign out_last[2] = if_c.data_out_0_last;
`else
  assign out_last[0] = 1'b0;
  assign out_last[1] = 1'b0;
  assign out_last[2] = 1'b0;
`endif

  // mode 0: ramp, 1: negative ramp, 2: 10*channel + pixel, other: constant 120
  function automatic logic [7:0] pix_val(input int mode, input int frame, input int idx, input int ch);
    int v;
    case (mode)
      0:       v = idx + 30 * frame;
      1:       v = -128 + idx + 30 * frame;
      2:       v = 10 * ch + idx;
      default: v = 120;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [7:0] win_max(input int mode, input int frame, input int w,
                                         input int orow, input int ocol, input int ch);
    logic signed [7:0] m, v;
    m = 8'sh80;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        v = $signed(pix_val(mode, frame, (orow * K + r) * w + ocol * K + c, ch));
        if (v > m) m = v;
      end
    end
    return m;
  endfunction

  task automatic drive_beats(input int d, input int mode, input int nbeats,
                             input int stall_start, input int stall_len, input bit chk_lat);
    exp_t            q[$];
    exp_t            e;
    logic [1:0][7:0] held;
    bit              was_stalled;
    int sent, cyc, fb, b, grp, col, row, frame, w, h, g, par;
    w = CFG_W[d]; h = CFG_H[d]; g = CFG_G[d]; par = CFG_PAR[d];
    fb = w * h * g;
    sent = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while ((sent < nbeats || q.size() != 0) && cyc < nbeats + stall_len + 20) begin
      b = sent % fb; frame = sent / fb;
      grp = b % g; col = (b / g) % w; row = b / (g * w);
      in_valid[d] = (sent < nbeats);
      for (int l = 0; l < 2; l++)
        in_dat[d][l] = (l < par) ? pix_val(mode, frame, row * w + col, grp * par + l) : 8'h00;
      out_ready[d] = !(cyc >= stall_start && cyc < stall_start + stall_len);
      #1;
      if (!out_ready[d] && out_valid[d]) begin
        n_checks++;
        if (in_ready[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_in_ready d=%0d cyc=%0d got=%b exp=0", d, cyc, in_ready[d]);
        end
        if (was_stalled) begin
          n_checks++;
          if (out_dat[d] !== held) begin
            n_fail++;
            $display("FAIL stall_hold d=%0d cyc=%0d got=%h exp=%h", d, cyc, out_dat[d], held);
          end
        end
        held = out_dat[d];
        was_stalled = 1'b1;
      end
      if (out_valid[d] && out_ready[d]) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output d=%0d cyc=%0d got=%h exp=none", d, cyc, out_dat[d]);
        end else begin
          e = q.pop_front();
          if (out_dat[d] !== e.dat) begin
            n_fail++;
            $display("FAIL data d=%0d cyc=%0d got=%h exp=%h", d, cyc, out_dat[d], e.dat);
          end
          if (chk_lat) begin
            n_checks++;
            if (cyc != e.cyc) begin
              n_fail++;
              $display("FAIL latency d=%0d got_cycle=%0d exp_cycle=%0d", d, cyc, e.cyc);
            end
          end
`ifdef STREAMING_MAX_POOL_LAST_EN
          n_checks++;
          if (out_last[d] !== e.last) begin
            n_fail++;
            $display("FAIL last d=%0d cyc=%0d got=%b exp=%b", d, cyc, out_last[d], e.last);
          end
`endif
        end
      end
      if (in_valid[d] && in_ready[d]) begin
        if (row % K == K - 1 && col % K == K - 1 && col < (w / K) * K && row < (h / K) * K) begin
          for (int l = 0; l < 2; l++)
            e.dat[l] = (l < par) ? win_max(mode, frame, w, row / K, col / K, grp * par + l) : 8'h00;
          e.cyc  = cyc + 1;
          e.last = (row / K == h / K - 1) && (col / K == w / K - 1) && (grp == g - 1);
          q.push_back(e);
        end
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    n_checks++;
    if (sent != nbeats || q.size() != 0) begin
      n_fail++;
      $display("FAIL drain d=%0d sent=%0d exp_sent=%0d pending=%0d exp_pending=0",
               d, sent, nbeats, q.size());
    end
  endtask

  task automatic check_idle_reset(input int d);
    n_checks++;
    if (out_valid[d] !== 1'b0 || out_dat[d] !== 16'h0000 || in_ready[d] !== 1'b1 ||
        out_last[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state d=%0d got vld=%b dat=%h rdy=%b last=%b exp vld=0 dat=0000 rdy=1 last=0",
               d, out_valid[d], out_dat[d], in_ready[d], out_last[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) check_idle_reset(d);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    drive_beats(0, 0, 16, -1, 0, 1'b1);
  endtask

  task automatic test_negative();
    drive_beats(0, 1, 16, -1, 0, 1'b1);
  endtask

  task automatic test_multichannel();
    drive_beats(1, 2, 64, -1, 0, 1'b1);
  endtask

  task automatic test_trailing();
    drive_beats(2, 0, 50, -1, 0, 1'b1);
  endtask

  task automatic test_back_pressure();
    drive_beats(0, 0, 16, 6, 10, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    drive_beats(0, 3, 5, -1, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_reset(0);
    @(negedge clk);
    rst = 1'b0;
    drive_beats(0, 0, 16, -1, 0, 1'b1);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      in_dat[d]    = '0;
    end
    test_reset();
    test_ramp();
    test_negative();
    test_multichannel();
    test_trailing();
    test_back_pressure();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
